msk_tx_burst_ctrl: RTL and testbench

Burst transmit controller that sequences the MSK modulator's serial `data_in`. It accepts a start command and payload length, then frames the burst as preamble, sync word, payload and tail. Payload bytes arrive on a valid/ready byte stream and are serialized MSB-first, each bit held for SPS clocks. It sits upstream of `msk_modulator_mdl`/`upconverter_mdl` and replaces hand-driven bench stimulus with a reusable sequencer.

---
 rtl/msk_ctrl_pkg.sv | 29 ++
 rtl/msk_bit_timer.sv | 45 ++++
 rtl/msk_tx_burst_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_msk_tx_burst_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/msk_ctrl_pkg.sv
// Package: msk_ctrl_pkg
// Shared types and defaults for the MSK burst transmit controller.
//   tx_state_t     - burst sequencer states
//   DEF_*          - default framing and timing parameters
//   burst_cycles() - total tx_en cycles of one burst for a given configuration
package msk_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SYNC,
        PAYLOAD,
        TAIL
    } tx_state_t;

    localparam int         DEF_SPS              = 20;     // 200 MHz / 10 Mb/s
    localparam int         DEF_PREAMBLE_BYTES   = 2;
    localparam logic [7:0] DEF_PREAMBLE_PATTERN = 8'hAA;
    localparam logic [7:0] DEF_SYNC_WORD        = 8'h1A;
    localparam int         DEF_TAIL_CYCLES      = 100;

    // Clocks of tx_en for one burst: every framed byte lasts 8*sps clocks,
    // followed by the forced-zero tail.
    function automatic int burst_cycles(input int preamble_bytes, input int len,
                                        input int sps, input int tail_cycles);
        return (preamble_bytes + 1 + len) * 8 * sps + tail_cycles;
    endfunction

endpackage

// File: rtl/msk_bit_timer.sv
// Module: msk_bit_timer
// Bit/byte timing for the serializer: sps_cnt runs 0..SPS-1, bit_idx runs 7..0.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   clr         - return counters to the start of a byte (sps_cnt=0, bit_idx=7)
//   en          - advance the counters
//   bit_tick    - last clock of the current bit
//   byte_tick   - last clock of the current byte (bit_tick on bit_idx 0)
module msk_bit_timer
    import msk_ctrl_pkg::*;
#(
    parameter int SPS = DEF_SPS
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic bit_tick,
    output logic byte_tick
);

    localparam logic [7:0] SPS_LAST = 8'(SPS - 1);

    logic [7:0] sps_cnt_reg;
    logic [2:0] bit_idx_reg;

    assign bit_tick  = en && (sps_cnt_reg == SPS_LAST);
    assign byte_tick = bit_tick && (bit_idx_reg == 3'd0);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            sps_cnt_reg <= 8'd0;
            bit_idx_reg <= 3'd7;
        end else if (en) begin
            if (sps_cnt_reg == SPS_LAST) begin
                sps_cnt_reg <= 8'd0;
                // 3-bit wrap takes bit_idx from 0 back to 7 at the byte boundary
                bit_idx_reg <= bit_idx_reg - 3'd1;
            end else begin
                sps_cnt_reg <= sps_cnt_reg + 8'd1;
            end
        end
    end

endmodule

// File: rtl/msk_tx_burst_ctrl.sv
// Module: msk_tx_burst_ctrl
// Burst sequencer feeding the MSK modulator's serial data input. A burst is
// preamble bytes, one sync byte, len payload bytes (MSB first, SPS clocks per
// bit) and TAIL_CYCLES clocks of forced-zero data.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   start, len  - burst request and payload length, sampled only in IDLE
//   byte_data, byte_valid, byte_ready - payload byte stream (valid/ready)
//   data_out    - registered serial bit to the modulator
//   tx_en       - high from the first preamble bit to the end of the tail
//   busy        - state is not IDLE
//   done        - one-cycle pulse when the burst ends
//   underrun    - one-cycle pulse when a payload byte was missing at its boundary
module msk_tx_burst_ctrl
    import msk_ctrl_pkg::*;
#(
    parameter int         SPS              = DEF_SPS,
    parameter int         PREAMBLE_BYTES   = DEF_PREAMBLE_BYTES,
    parameter logic [7:0] PREAMBLE_PATTERN = DEF_PREAMBLE_PATTERN,
    parameter logic [7:0] SYNC_WORD        = DEF_SYNC_WORD,
    parameter int         TAIL_CYCLES      = DEF_TAIL_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] len,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       data_out,
    output logic       tx_en,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam logic [7:0]  PRE_LAST  = 8'(PREAMBLE_BYTES - 1);
    localparam logic [15:0] TAIL_LAST = 16'(TAIL_CYCLES - 1);

    tx_state_t   state_reg;
    logic [7:0]  shift_reg;
    logic [7:0]  len_reg;
    logic [7:0]  fetched_reg;
    logic [7:0]  byte_cnt_reg;   // preamble byte index, or payload bytes loaded
    logic [7:0]  hold_reg;
    logic        hold_v_reg;
    logic [7:0]  skip_reg;       // late bytes still owed for underrun slots
    logic [15:0] tail_cnt_reg;
    logic        data_out_reg;
    logic        tx_en_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        underrun_reg;

    logic        bit_tick;
    logic        byte_tick;
    logic        timer_en;
    logic        timer_clr;
    logic        handshake;
    logic        payload_boundary;
    logic        direct_taken;
    logic        skip_inc;
    logic        skip_dec;
    logic [7:0]  pay_byte;
    logic        pay_from_hold;
    logic        pay_direct;
    logic        pay_underrun;

    assign data_out = data_out_reg;
    assign tx_en    = tx_en_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign underrun = underrun_reg;

    // Purely from registered state, so there is no path from byte_valid.
    assign byte_ready = ((state_reg == SYNC) || (state_reg == PAYLOAD))
                        && !hold_v_reg && (fetched_reg < len_reg);
    assign handshake  = byte_valid && byte_ready;

    assign timer_en  = (state_reg == PREAMBLE) || (state_reg == SYNC) || (state_reg == PAYLOAD);
    assign timer_clr = (state_reg == IDLE);

    msk_bit_timer #(
        .SPS(SPS)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (timer_clr),
        .en       (timer_en),
        .bit_tick (bit_tick),
        .byte_tick(byte_tick)
    );

    // Edge at which the next byte to shift out is a payload byte.
    assign payload_boundary = byte_tick &&
        (((state_reg == SYNC) && (len_reg != 8'd0)) ||
         ((state_reg == PAYLOAD) && (byte_cnt_reg != len_reg)));

    // Source of the payload byte loaded at a boundary. A handshake while late
    // bytes are still owed belongs to an earlier slot, so it is not used here.
    always_comb begin
        pay_byte      = 8'h00;
        pay_from_hold = 1'b0;
        pay_direct    = 1'b0;
        pay_underrun  = 1'b0;
        if (hold_v_reg) begin
            pay_byte      = hold_reg;
            pay_from_hold = 1'b1;
        end else if (handshake && (skip_reg == 8'd0)) begin
            pay_byte   = byte_data;
            pay_direct = 1'b1;
        end else begin
            pay_underrun = 1'b1;
        end
    end

    assign direct_taken = payload_boundary && pay_direct;
    assign skip_inc     = payload_boundary && pay_underrun;
    assign skip_dec     = handshake && !direct_taken && (skip_reg != 8'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            shift_reg    <= 8'h00;
            len_reg      <= 8'd0;
            fetched_reg  <= 8'd0;
            byte_cnt_reg <= 8'd0;
            hold_reg     <= 8'h00;
            hold_v_reg   <= 1'b0;
            skip_reg     <= 8'd0;
            tail_cnt_reg <= 16'd0;
            data_out_reg <= 1'b0;
            tx_en_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            underrun_reg <= 1'b0;

            // Fetch side: every transfer counts, whether kept or discarded.
            if (handshake) begin
                fetched_reg <= fetched_reg + 8'd1;
            end
            if (payload_boundary && pay_from_hold) begin
                hold_v_reg <= 1'b0;
            end
            if (handshake && !direct_taken && (skip_reg == 8'd0)) begin
                hold_reg   <= byte_data;
                hold_v_reg <= 1'b1;
            end
            if (skip_inc && !skip_dec) begin
                skip_reg <= skip_reg + 8'd1;
            end else if (skip_dec && !skip_inc) begin
                skip_reg <= skip_reg - 8'd1;
            end

            unique case (state_reg)
                IDLE: begin
                    data_out_reg <= 1'b0;
                    tx_en_reg    <= 1'b0;
                    busy_reg     <= 1'b0;
                    if (start) begin
                        len_reg      <= len;
                        fetched_reg  <= 8'd0;
                        byte_cnt_reg <= 8'd0;
                        hold_v_reg   <= 1'b0;
                        skip_reg     <= 8'd0;
                        tx_en_reg    <= 1'b1;
                        busy_reg     <= 1'b1;
                        if (PREAMBLE_BYTES == 0) begin
                            state_reg    <= SYNC;
                            shift_reg    <= SYNC_WORD;
                            data_out_reg <= SYNC_WORD[7];
                        end else begin
                            state_reg    <= PREAMBLE;
                            shift_reg    <= PREAMBLE_PATTERN;
                            data_out_reg <= PREAMBLE_PATTERN[7];
                        end
                    end
                end

                PREAMBLE: begin
                    if (byte_tick) begin
                        if (byte_cnt_reg == PRE_LAST) begin
                            state_reg    <= SYNC;
                            byte_cnt_reg <= 8'd0;
                            shift_reg    <= SYNC_WORD;
                            data_out_reg <= SYNC_WORD[7];
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 8'd1;
                            shift_reg    <= PREAMBLE_PATTERN;
                            data_out_reg <= PREAMBLE_PATTERN[7];
                        end
                    end else if (bit_tick) begin
                        shift_reg    <= {shift_reg[6:0], 1'b0};
                        data_out_reg <= shift_reg[6];
                    end
                end

                SYNC: begin
                    if (byte_tick) begin
                        if (len_reg == 8'd0) begin
                            state_reg    <= TAIL;
                            tail_cnt_reg <= 16'd0;
                            data_out_reg <= 1'b0;
                        end else begin
                            state_reg    <= PAYLOAD;
                            byte_cnt_reg <= 8'd1;
                            shift_reg    <= pay_byte;
                            data_out_reg <= pay_byte[7];
                            underrun_reg <= pay_underrun;
                        end
                    end else if (bit_tick) begin
                        shift_reg    <= {shift_reg[6:0], 1'b0};
                        data_out_reg <= shift_reg[6];
                    end
                end

                PAYLOAD: begin
                    if (byte_tick) begin
                        if (byte_cnt_reg == len_reg) begin
                            state_reg    <= TAIL;
                            tail_cnt_reg <= 16'd0;
                            data_out_reg <= 1'b0;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 8'd1;
                            shift_reg    <= pay_byte;
                            data_out_reg <= pay_byte[7];
                            underrun_reg <= pay_underrun;
                        end
                    end else if (bit_tick) begin
                        shift_reg    <= {shift_reg[6:0], 1'b0};
                        data_out_reg <= shift_reg[6];
                    end
                end

                TAIL: begin
                    data_out_reg <= 1'b0;
                    if (tail_cnt_reg == TAIL_LAST) begin
                        state_reg <= IDLE;
                        tx_en_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        tail_cnt_reg <= tail_cnt_reg + 16'd1;
                    end
                end

                default: begin
                    state_reg    <= IDLE;
                    data_out_reg <= 1'b0;
                    tx_en_reg    <= 1'b0;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msk_tx_burst_ctrl.sv
module tb_msk_tx_burst_ctrl;

    localparam int SPS    = 20;
    localparam int BUDGET = 3000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] len = 8'd0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic       data_out;
    logic       tx_en;
    logic       busy;
    logic       done;
    logic       underrun;

    int checks = 0;
    int failures = 0;

    // Per-burst observations
    logic       bits [0:2047];
    logic [7:0] pay [0:7];
    int         txen_cnt, ready_cnt, ready_after, hs_cnt, ur_cnt, ur_cyc, done_cyc;
    logic       first_txen, busy_at_done, txen_at_done;
    bit         done_seen;

    always #5 clk = ~clk;

    msk_tx_burst_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .data_out  (data_out),
        .tx_en     (tx_en),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun)
    );

    // Byte b of the recorded burst, sampled mid-bit.
    function automatic logic [7:0] get_byte(input int b);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[7-j] = bits[b*8*SPS + j*SPS + SPS/2];
        return r;
    endfunction

    // Cycles where data_out differs from the first cycle of its bit period.
    function automatic int hold_errs(input int nbytes);
        int e = 0;
        for (int k = 0; k < nbytes*8*SPS; k++)
            if (bits[k] !== bits[k - (k % SPS)]) e++;
        return e;
    endfunction

    function automatic int tail_ones(input int from, input int n);
        int e = 0;
        for (int k = from; k < from + n; k++)
            if (bits[k] !== 1'b0) e++;
        return e;
    endfunction

    // Runs one burst, observing at negedges. Cycle 0 is the first cycle after
    // the edge that samples start. Inputs for the next edge are driven here.
    task automatic run_burst(input logic [7:0] l, input int nsup, input int vmode,
                             input int abort_at, input int busy_start_at,
                             input bit prestarted, input bit b2b_next,
                             input logic [7:0] b2b_len);
        int idx = 0;
        txen_cnt = 0; ready_cnt = 0; ready_after = 0; hs_cnt = 0;
        ur_cnt = 0; ur_cyc = -1; done_cyc = -1; done_seen = 0;
        first_txen = 1'b0; busy_at_done = 1'b1; txen_at_done = 1'b1;
        for (int k = 0; k < 2048; k++) bits[k] = 1'b0;
        if (!prestarted) begin
            @(negedge clk);
            start = 1'b1;
            len = l;
            byte_valid = 1'b0;
        end
        for (int cc = 0; cc < BUDGET; cc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cc == abort_at) return;
            if (cc == busy_start_at) begin
                start = 1'b1;
                len = 8'd5;
            end
            if (cc == 0) first_txen = tx_en;
            if (tx_en === 1'b1) txen_cnt++;
            if (cc < 2048) bits[cc] = data_out;
            if (byte_ready === 1'b1) begin
                ready_cnt++;
                if (hs_cnt >= int'(l)) ready_after++;
            end
            if (underrun === 1'b1) begin
                ur_cnt++;
                ur_cyc = cc;
            end
            if (done === 1'b1) begin
                done_seen = 1;
                done_cyc = cc;
                busy_at_done = busy;
                txen_at_done = tx_en;
                byte_valid = 1'b0;
                if (b2b_next) begin
                    start = 1'b1;
                    len = b2b_len;
                end
                break;
            end
            byte_valid = (idx < nsup) && (vmode == 0 || ((cc / 37) % 2 == 0));
            byte_data = (idx < nsup) ? pay[idx] : 8'h00;
            if (byte_valid && byte_ready) begin
                hs_cnt++;
                idx++;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (data_out !== 1'b0) begin failures++; $display("FAIL reset_data_out: got %b expected 0", data_out); end
        checks++; if (tx_en !== 1'b0) begin failures++; $display("FAIL reset_tx_en: got %b expected 0", tx_en); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        checks++; if (byte_ready !== 1'b0) begin failures++; $display("FAIL reset_byte_ready: got %b expected 0", byte_ready); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", busy); end
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_nominal();
        logic [7:0] exp_b [0:5];
        exp_b = '{8'hAA, 8'hAA, 8'h1A, 8'h10, 8'h33, 8'hFF};
        pay[0] = 8'h10; pay[1] = 8'h33; pay[2] = 8'hFF;
        run_burst(8'd3, 3, 0, -1, -1, 0, 0, 8'd0);
        checks++; if (!done_seen) begin failures++; $display("FAIL nominal_done_timeout: got no done expected done within %0d", BUDGET); end
        checks++; if (first_txen !== 1'b1) begin failures++; $display("FAIL nominal_start_latency: got tx_en=%b expected 1", first_txen); end
        checks++; if (txen_cnt !== 1060) begin failures++; $display("FAIL nominal_txen_len: got %0d expected 1060", txen_cnt); end
        checks++; if (done_cyc !== 1060) begin failures++; $display("FAIL nominal_done_cycle: got %0d expected 1060", done_cyc); end
        for (int b = 0; b < 6; b++) begin
            checks++;
            if (get_byte(b) !== exp_b[b]) begin failures++; $display("FAIL nominal_byte%0d: got %h expected %h", b, get_byte(b), exp_b[b]); end
        end
        checks++; if (hold_errs(6) !== 0) begin failures++; $display("FAIL nominal_bit_hold: got %0d glitches expected 0", hold_errs(6)); end
        checks++; if (tail_ones(960, 100) !== 0) begin failures++; $display("FAIL nominal_tail_zero: got %0d ones expected 0", tail_ones(960, 100)); end
        checks++; if (hs_cnt !== 3) begin failures++; $display("FAIL nominal_handshakes: got %0d expected 3", hs_cnt); end
        checks++; if (ur_cnt !== 0) begin failures++; $display("FAIL nominal_underrun: got %0d expected 0", ur_cnt); end
        checks++; if (busy_at_done !== 1'b0 || txen_at_done !== 1'b0) begin failures++; $display("FAIL nominal_done_state: got busy=%b tx_en=%b expected 0 0", busy_at_done, txen_at_done); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL nominal_done_pulse: got %b expected 0", done); end
        $display("test_nominal done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_zero_len();
        logic [7:0] exp_b [0:2];
        exp_b = '{8'hAA, 8'hAA, 8'h1A};
        run_burst(8'd0, 0, 0, -1, -1, 0, 0, 8'd0);
        checks++; if (!done_seen) begin failures++; $display("FAIL zero_done_timeout: got no done expected done within %0d", BUDGET); end
        checks++; if (txen_cnt !== 580) begin failures++; $display("FAIL zero_txen_len: got %0d expected 580", txen_cnt); end
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (get_byte(b) !== exp_b[b]) begin failures++; $display("FAIL zero_byte%0d: got %h expected %h", b, get_byte(b), exp_b[b]); end
        end
        checks++; if (ready_cnt !== 0) begin failures++; $display("FAIL zero_byte_ready: got %0d cycles expected 0", ready_cnt); end
        checks++; if (tail_ones(480, 100) !== 0) begin failures++; $display("FAIL zero_tail_zero: got %0d ones expected 0", tail_ones(480, 100)); end
        $display("test_zero_len done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_underrun();
        logic [7:0] exp_b [0:4];
        exp_b = '{8'hAA, 8'hAA, 8'h1A, 8'h55, 8'h00};
        pay[0] = 8'h55;
        run_burst(8'd2, 1, 0, -1, -1, 0, 0, 8'd0);
        checks++; if (!done_seen) begin failures++; $display("FAIL underrun_done_timeout: got no done expected done within %0d", BUDGET); end
        checks++; if (txen_cnt !== 900) begin failures++; $display("FAIL underrun_txen_len: got %0d expected 900", txen_cnt); end
        for (int b = 0; b < 5; b++) begin
            checks++;
            if (get_byte(b) !== exp_b[b]) begin failures++; $display("FAIL underrun_byte%0d: got %h expected %h", b, get_byte(b), exp_b[b]); end
        end
        checks++; if (ur_cnt !== 1) begin failures++; $display("FAIL underrun_count: got %0d expected 1", ur_cnt); end
        checks++; if (ur_cyc !== 640) begin failures++; $display("FAIL underrun_cycle: got %0d expected 640", ur_cyc); end
        $display("test_underrun done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_b [0:5];
        exp_b = '{8'hAA, 8'hAA, 8'h1A, 8'h5A, 8'hC3, 8'h81};
        pay[0] = 8'h5A; pay[1] = 8'hC3; pay[2] = 8'h81;
        run_burst(8'd3, 3, 1, -1, -1, 0, 0, 8'd0);
        checks++; if (!done_seen) begin failures++; $display("FAIL bp_done_timeout: got no done expected done within %0d", BUDGET); end
        checks++; if (txen_cnt !== 1060) begin failures++; $display("FAIL bp_txen_len: got %0d expected 1060", txen_cnt); end
        for (int b = 0; b < 6; b++) begin
            checks++;
            if (get_byte(b) !== exp_b[b]) begin failures++; $display("FAIL bp_byte%0d: got %h expected %h", b, get_byte(b), exp_b[b]); end
        end
        checks++; if (hs_cnt !== 3) begin failures++; $display("FAIL bp_handshakes: got %0d expected 3", hs_cnt); end
        checks++; if (ready_after !== 0) begin failures++; $display("FAIL bp_ready_after_len: got %0d cycles expected 0", ready_after); end
        checks++; if (ur_cnt !== 0) begin failures++; $display("FAIL bp_underrun: got %0d expected 0", ur_cnt); end
        $display("test_backpressure done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_b [0:3];
        exp_b = '{8'hAA, 8'hAA, 8'h1A, 8'hC3};
        pay[0] = 8'h10; pay[1] = 8'h33; pay[2] = 8'hFF;
        run_burst(8'd3, 3, 0, 400, -1, 0, 0, 8'd0);
        reset = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        checks++; if ({data_out, tx_en, busy, done, underrun, byte_ready} !== 6'b0) begin
            failures++; $display("FAIL midreset_outputs: got %b expected 000000", {data_out, tx_en, busy, done, underrun, byte_ready});
        end
        reset = 1'b0;
        pay[0] = 8'hC3;
        run_burst(8'd1, 1, 0, -1, -1, 0, 0, 8'd0);
        checks++; if (!done_seen) begin failures++; $display("FAIL midreset_done_timeout: got no done expected done within %0d", BUDGET); end
        checks++; if (txen_cnt !== 740) begin failures++; $display("FAIL midreset_txen_len: got %0d expected 740", txen_cnt); end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (get_byte(b) !== exp_b[b]) begin failures++; $display("FAIL midreset_byte%0d: got %h expected %h", b, get_byte(b), exp_b[b]); end
        end
        checks++; if (ur_cnt !== 0) begin failures++; $display("FAIL midreset_underrun: got %0d expected 0", ur_cnt); end
        $display("test_reset_mid done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [0:3];
        exp_b = '{8'hAA, 8'hAA, 8'h1A, 8'h3C};
        pay[0] = 8'h3C;
        // start pulsed at cycle 100 while busy; start held in the done cycle
        run_burst(8'd1, 1, 0, -1, 100, 0, 1, 8'd0);
        checks++; if (!done_seen) begin failures++; $display("FAIL b2b_first_done_timeout: got no done expected done within %0d", BUDGET); end
        checks++; if (txen_cnt !== 740) begin failures++; $display("FAIL b2b_busy_start_ignored: got tx_en %0d expected 740", txen_cnt); end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (get_byte(b) !== exp_b[b]) begin failures++; $display("FAIL b2b_first_byte%0d: got %h expected %h", b, get_byte(b), exp_b[b]); end
        end
        run_burst(8'd0, 0, 0, -1, -1, 1, 0, 8'd0);
        checks++; if (first_txen !== 1'b1) begin failures++; $display("FAIL b2b_restart: got tx_en=%b expected 1", first_txen); end
        checks++; if (txen_cnt !== 580) begin failures++; $display("FAIL b2b_second_len: got %0d expected 580", txen_cnt); end
        checks++; if (get_byte(2) !== 8'h1A) begin failures++; $display("FAIL b2b_second_sync: got %h expected 1a", get_byte(2)); end
        checks++; if (!done_seen) begin failures++; $display("FAIL b2b_second_done_timeout: got no done expected done within %0d", BUDGET); end
        $display("test_back_to_back done checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_zero_len();
        test_underrun();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
